// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Purpose  : Types and helpers shared by the UART transmit and receive paths.
//            tx_state_t   - frame state of the transmitter
//            clks_per_bit - system clocks per line bit (integer divide)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock pointer FIFO, first-word-fall-through head.
//            Pointers carry one extra wrap bit so full and empty are told
//            apart without a separate flag.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            wr_en/wr_data - write request (ignored while full)
//            rd_en         - pop the head (ignored while empty)
//            rd_data       - current head entry, valid while !empty
//            count         - entries held (0..DEPTH)
//            full, empty   - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_aw = $clog2(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [c_aw:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [c_aw:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic             w_push, w_pop;

    // A full FIFO never accepts a write, even if a read frees a slot in the
    // same cycle; the producer sees the space one cycle later.
    assign w_push = wr_en && !full;
    assign w_pop  = rd_en && !empty;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        if (w_push) w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        if (w_pop)  w_rd_ptr_d = r_rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
        end
    end

    // Storage is not reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem_q[r_wr_ptr_q[c_aw-1:0]] <= wr_data;
    end

    // Head is read straight out of the storage flops, so it is valid the
    // cycle after the write that made the FIFO non-empty.
    assign rd_data = r_mem_q[r_rd_ptr_q[c_aw-1:0]];
    assign count   = r_wr_ptr_q - r_rd_ptr_q;
    assign empty   = (r_wr_ptr_q == r_rd_ptr_q);
    assign full    = (r_wr_ptr_q[c_aw] != r_rd_ptr_q[c_aw]) &&
                     (r_wr_ptr_q[c_aw-1:0] == r_rd_ptr_q[c_aw-1:0]);

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : UART 8N1 transmitter fed from a byte FIFO. Back-to-back bytes
//            are sent with the next start bit directly after the stop bit.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            data_in    - byte to queue
//            data_valid - producer offers data_in
//            data_ready - FIFO not full
//            tx         - serial line, idle high, registered
//            busy       - frame in progress or bytes queued
//            fifo_count - bytes currently queued
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_clks_per_bit = clks_per_bit(CLK_HZ, BAUD);
    localparam int c_bw           = $clog2(c_clks_per_bit);
    localparam logic [c_bw-1:0] c_baud_last = c_bw'(c_clks_per_bit - 1);

    generate
        if (c_clks_per_bit < 2) begin : g_bad_baud
            $error("uart_tx_fifo: CLK_HZ/BAUD must be at least 2");
        end
    endgenerate

    tx_state_t       r_state_q, w_state_d;
    logic [c_bw-1:0] r_baud_q,  w_baud_d;
    logic [2:0]      r_bit_q,   w_bit_d;
    logic [7:0]      r_shift_q, w_shift_d;
    logic            r_tx_q,    w_tx_d;

    logic            w_pop;
    logic [7:0]      w_head;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_baud_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (data_valid),
        .wr_data (data_in),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .count   (fifo_count),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    // full is exactly fifo_count == FIFO_DEPTH, taken from the pointer flops.
    assign data_ready  = !w_fifo_full;
    assign busy        = (r_state_q != IDLE) || !w_fifo_empty;
    assign tx          = r_tx_q;
    assign w_baud_done = (r_baud_q == c_baud_last);

    always_comb begin
        w_state_d = r_state_q;
        w_baud_d  = r_baud_q + 1'b1;
        w_bit_d   = r_bit_q;
        w_shift_d = r_shift_q;
        w_pop     = 1'b0;

        case (r_state_q)
            IDLE: begin
                w_baud_d = '0;
                if (!w_fifo_empty) begin
                    w_pop     = 1'b1;
                    w_shift_d = w_head;
                    w_state_d = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_d  = '0;
                    w_bit_d   = 3'd0;
                    w_state_d = DATA;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_d  = '0;
                    w_shift_d = {1'b0, r_shift_q[7:1]};
                    if (r_bit_q == 3'd7) begin
                        w_state_d = STOP;
                    end else begin
                        w_bit_d = r_bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_d = '0;
                    // Chain straight into the next start bit when more data
                    // is waiting, so there is no idle gap between frames.
                    if (!w_fifo_empty) begin
                        w_pop     = 1'b1;
                        w_shift_d = w_head;
                        w_state_d = START;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: begin
                w_baud_d  = '0;
                w_state_d = IDLE;
            end
        endcase

        // The line level is derived from the next state so the registered
        // tx changes on the same edge as the state it belongs to.
        case (w_state_d)
            START:   w_tx_d = 1'b0;
            DATA:    w_tx_d = w_shift_d[0];
            default: w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_baud_q  <= '0;
            r_bit_q   <= '0;
            r_shift_q <= '0;
            r_tx_q    <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_baud_q  <= w_baud_d;
            r_bit_q   <= w_bit_d;
            r_shift_q <= w_shift_d;
            r_tx_q    <= w_tx_d;
        end
    end

endmodule : uart_tx_fifo
`default_nettype wire
